legv8_multicycle_ctrl: RTL
==========================

# legv8_multicycle_ctrl

Multicycle sequencer for the LEGv8 register-file/ALU/data-memory datapath. It accepts one 32-bit instruction at a time over a valid/ready handshake and decodes the instruction fields. It then steps through DECODE/EXEC/MEM/WB states, driving the datapath's register addresses, ALU control, operand mux and memory strobes. It sits between the instruction source and the datapath, reports completion and branch outcome, and counts retired instructions.

## Interface

- CNT_WIDTH, 16, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  instr holds a new instruction
- instr  in  32  LEGv8 instruction word
- instr_ready  out  1  controller can accept an instruction (high only in IDLE)
- Zero  in  1  datapath ALU zero flag
- rd_addr_1  out  5  Rn, instr[9:5]
- rd_addr_2  out  5  Rm instr[20:16] for R-type; Rt instr[4:0] for STUR/CBZ
- wr_addr  out  5  Rd/Rt, instr[4:0]
- displacement  out  9  instr[20:12]
- Opcode_field  out  11  instr[31:21]
- ALUOp  out  2  00 LDUR/STUR, 01 CBZ, 10 R-type
- ALUSrc  out  1  1 for LDUR/STUR
- RegWrite, MemWrite, MemRead, MemtoReg  out  1 each  datapath strobes
- done  out  1  one-cycle pulse in the final cycle of each instruction
- branch_taken  out  1  valid with done for CBZ
- illegal  out  1  valid with done: the opcode is not supported
- retired_cnt  out  CNT_WIDTH  count of completed legal instructions

## Operation

- Supported opcodes are ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, and CBZ instr[31:24]=10110100. Any other opcode is illegal.
- States are IDLE, DECODE, EXEC, MEM, WB, BR.
- IDLE: instr_ready=1. When instr_valid=1, latch instr into ir and go to DECODE. No other transfer happens.
- DECODE: address, displacement and Opcode_field outputs are driven from ir. An illegal opcode asserts done=1 and illegal=1, then returns to IDLE. A legal opcode goes to EXEC.
- EXEC: the ALU computes. R-type goes to WB, LDUR/STUR to MEM, and CBZ to BR. The Zero value sampled on this cycle's edge becomes branch_taken.
- MEM: LDUR asserts MemRead=1 and goes to WB. STUR asserts MemWrite=1 and done=1, then returns to IDLE.
- WB: asserts RegWrite=1 and done=1, then returns to IDLE. For LDUR, MemRead=1 and MemtoReg=1 stay asserted.
- BR: asserts done=1, with branch_taken taken from the registered Zero value, then returns to IDLE.
- The following outputs come from ir and hold stable in every non-IDLE state: rd_addr_1, rd_addr_2, wr_addr, displacement, Opcode_field, ALUOp, ALUSrc. This keeps ALU_result, and therefore the memory address, stable through MEM and WB.
- In IDLE, all datapath control outputs, done, branch_taken and illegal are 0.
- RegWrite and MemWrite are asserted for exactly one cycle per instruction and never both in the same instruction.
- retired_cnt increments by 1 on each done with illegal=0. It wraps from 2^CNT_WIDTH-1 to 0. Illegal instructions are not counted.

## Timing

- Reset (reset=0, asynchronous) forces state to IDLE, ir=0, branch_taken register=0 and retired_cnt=0.
  - All outputs take their IDLE values immediately: instr_ready=1 and everything else 0.
  - A reset mid-instruction abandons it with no further strobes.
  - The first accept can occur on the first rising edge after reset is released.
- Latency counts cycles from the accepting edge to the done cycle inclusive:
  - illegal: 1
  - R-type: 3
  - STUR: 3
  - CBZ: 3
  - LDUR: 4
- done is high in the last cycle. instr_ready returns high the next cycle.
- Back-to-back issue: there is one IDLE cycle between instructions. Throughput is at best one instruction per 4 cycles (2 for illegal).
- instr_valid while busy is ignored. The instruction source must hold instr_valid and instr until instr_ready=1.
- Zero is sampled only in EXEC of CBZ. It is ignored at all other times.
- All outputs are functions of registered state and ir only, so there are no combinational paths from inputs to outputs.

## Test plan

- Reset then ADD X3,X1,X2 (0x8B020023):
  - Accept at edge 0.
  - Next cycle rd_addr_1=1, rd_addr_2=2, ALUOp=10, ALUSrc=0.
  - RegWrite=1 and wr_addr=3 only in cycle 3, with done=1 there.
  - retired_cnt ends at 1.
- LDUR X5,[X1,#8] (0xF8408025):
  - displacement=8, ALUSrc=1, ALUOp=00.
  - MemRead=1 in cycles 3-4.
  - RegWrite=1 and MemtoReg=1 only in cycle 4, with done in cycle 4.
- STUR X5,[X1,#-1] (0xF81FF025):
  - displacement=0x1FF, rd_addr_2=5.
  - MemWrite=1 only in cycle 3, RegWrite stays 0.
- CBZ X4 (0xB4000044):
  - With Zero=1 during EXEC: done in cycle 3 with branch_taken=1.
  - Repeat with Zero=0: branch_taken=0.
  - No RegWrite or MemWrite in either run.
- Opcode 0x00000000: done=1 and illegal=1 in cycle 1, no strobes, retired_cnt unchanged.
- Counter and abort:
  - Preload to 0xFFFF via 65535 ADDs (or force); one more ADD wraps retired_cnt to 0.
  - Separately, drive reset low during MEM of LDUR: outputs go to 0 and instr_ready=1 immediately, with no RegWrite.
  - Hold instr_valid=1 while busy: no second accept before instr_ready.

Source files
------------

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 sequencer: accepts one instruction over valid/ready and
// walks it through DECODE/EXEC/MEM/WB/BR. It drives the register addresses,
// ALU control and memory strobes, and counts retired instructions.
module legv8_multicycle_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic [31:0]          instr,
    output logic                 instr_ready,
    input  logic                 Zero,
    output logic [4:0]           rd_addr_1,
    output logic [4:0]           rd_addr_2,
    output logic [4:0]           wr_addr,
    output logic [8:0]           displacement,
    output logic [10:0]          Opcode_field,
    output logic [1:0]           ALUOp,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 MemRead,
    output logic                 MemtoReg,
    output logic                 done,
    output logic                 branch_taken,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic                 zero_q, zero_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic is_r, is_ldur, is_stur, is_cbz, is_legal, busy;
    logic unused_bits;

    // The shift-amount field is not used by any supported instruction.
    assign unused_bits = ^ir_q[15:10];

    // Opcode classification of the held instruction.
    always_comb begin
        is_r     = (ir_q[31:21] == OP_ADD) || (ir_q[31:21] == OP_SUB) ||
                   (ir_q[31:21] == OP_AND) || (ir_q[31:21] == OP_ORR);
        is_ldur  = (ir_q[31:21] == OP_LDUR);
        is_stur  = (ir_q[31:21] == OP_STUR);
        is_cbz   = (ir_q[31:24] == OP_CBZ);
        is_legal = is_r || is_ldur || is_stur || is_cbz;
        busy     = (state_q != S_IDLE);
    end

    // Next-state logic and all outputs; outputs depend only on registered state.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        zero_d       = zero_q;
        cnt_d        = cnt_q;
        instr_ready  = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        MemtoReg     = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        branch_taken = 1'b0;

        // Datapath fields are held steady from ir for the whole instruction.
        rd_addr_1    = busy ? ir_q[9:5] : 5'd0;
        rd_addr_2    = !busy ? 5'd0 : ((is_stur || is_cbz) ? ir_q[4:0] : ir_q[20:16]);
        wr_addr      = busy ? ir_q[4:0] : 5'd0;
        displacement = busy ? ir_q[20:12] : 9'd0;
        Opcode_field = busy ? ir_q[31:21] : 11'd0;
        ALUOp        = !busy ? 2'b00 : (is_cbz ? 2'b01 : (is_r ? 2'b10 : 2'b00));
        ALUSrc       = busy && (is_ldur || is_stur);

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    done    = 1'b1;
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (is_cbz) begin
                    zero_d  = Zero;
                    state_d = S_BR;
                end else if (is_r) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                if (is_ldur) begin
                    MemRead = 1'b1;
                    state_d = S_WB;
                end else begin
                    MemWrite = 1'b1;
                    done     = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                done     = 1'b1;
                MemRead  = is_ldur;
                MemtoReg = is_ldur;
                state_d  = S_IDLE;
            end
            S_BR: begin
                branch_taken = zero_q;
                done         = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (done && !illegal) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        retired_cnt = cnt_q;
    end

    // State, instruction, branch flag and retire counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ir_q    <= 32'd0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
